// File: rtl/jpeg_feed_ctrl.sv
// jpeg_feed_ctrl: streams one compressed JPEG image from a word-wide source
// into the decoder input FIFO, then waits for the decoder to go idle again.
// Software supplies a word count and a start strobe. Completion is signalled
// by a sticky interrupt. Error covers a zero-length job or a drain timeout.
module jpeg_feed_ctrl #(
    parameter int LEN_W   = 24,
    parameter int RST_CYC = 4,
    parameter int TO_W    = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] start_len,
    input  logic             abort,
    output logic             rd_req,
    output logic [LEN_W-1:0] rd_adr,
    input  logic             rd_ack,
    input  logic [31:0]      rd_data,
    output logic             fifo_we,
    output logic [31:0]      fifo_wd,
    input  logic             fifo_full,
    input  logic             fifo_almfull,
    input  logic             jpeg_idle,
    output logic             dec_reset,
    output logic             busy,
    output logic             done_irq,
    input  logic             irq_clr,
    output logic             err,
    output logic [LEN_W-1:0] words_left
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RST   = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Counter just wide enough to count RST_CYC cycles (at least one bit).
    localparam int               RC_W    = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RST_CYC - 1);
    localparam logic [TO_W-1:0]  TO_MAX  = {TO_W{1'b1}};

    state_t           state_q;
    logic [LEN_W-1:0] words_left_q;
    logic [LEN_W-1:0] words_left_d;
    logic [LEN_W-1:0] rd_adr_q;
    logic [LEN_W-1:0] rd_adr_d;
    logic [RC_W-1:0]  rst_cnt_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic [TO_W-1:0]  to_cnt_d;
    logic             seen_busy_q;
    logic             fifo_we_q;
    logic [31:0]      fifo_wd_q;
    logic             dec_reset_q;
    logic             done_irq_q;
    logic             err_q;
    logic             can_req;
    logic             xfer;

    // Request qualification and counter next values. The request path is
    // combinational so that almost-full and abort take effect in the same cycle.
    always_comb begin
        can_req      = 1'b0;
        xfer         = 1'b0;
        words_left_d = words_left_q - LEN_W'(1);
        rd_adr_d     = rd_adr_q + LEN_W'(1);
        to_cnt_d     = to_cnt_q + TO_W'(1);
        if ((state_q == S_FEED) && (words_left_q != '0) &&
            !fifo_almfull && !fifo_full && !abort) begin
            can_req = 1'b1;
        end else begin
            can_req = 1'b0;
        end
        xfer = can_req & rd_ack;
    end

    // Job sequencer: state, counters and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            words_left_q <= '0;
            rd_adr_q     <= '0;
            rst_cnt_q    <= '0;
            to_cnt_q     <= '0;
            seen_busy_q  <= 1'b0;
            fifo_we_q    <= 1'b0;
            fifo_wd_q    <= 32'd0;
            dec_reset_q  <= 1'b0;
            done_irq_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // A word accepted this cycle is written one cycle later, even if
            // the job is aborted in between.
            fifo_we_q <= xfer;
            if (xfer) begin
                fifo_wd_q <= rd_data;
            end

            // Clear first so a completion in the same cycle wins below.
            if (irq_clr) begin
                done_irq_q <= 1'b0;
            end

            if (abort && (state_q != S_IDLE)) begin
                state_q     <= S_IDLE;
                dec_reset_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start && !abort) begin
                            words_left_q <= start_len;
                            rd_adr_q     <= '0;
                            rst_cnt_q    <= '0;
                            to_cnt_q     <= '0;
                            seen_busy_q  <= 1'b0;
                            err_q        <= (start_len == '0);
                            if (start_len == '0) begin
                                state_q <= S_DONE;
                            end else begin
                                state_q     <= S_RST;
                                dec_reset_q <= 1'b1;
                            end
                        end
                    end
                    S_RST: begin
                        if (rst_cnt_q == RC_LAST) begin
                            dec_reset_q <= 1'b0;
                            state_q     <= S_FEED;
                        end else begin
                            rst_cnt_q <= rst_cnt_q + RC_W'(1);
                        end
                    end
                    S_FEED: begin
                        if (xfer) begin
                            words_left_q <= words_left_d;
                            rd_adr_q     <= rd_adr_d;
                            if (words_left_q == LEN_W'(1)) begin
                                state_q <= S_DRAIN;
                            end
                        end
                    end
                    S_DRAIN: begin
                        to_cnt_q <= to_cnt_d;
                        if (!jpeg_idle) begin
                            seen_busy_q <= 1'b1;
                        end
                        // A clean finish takes priority over a coincident timeout.
                        if (seen_busy_q && jpeg_idle) begin
                            state_q <= S_DONE;
                        end else if (to_cnt_d == TO_MAX) begin
                            err_q   <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        done_irq_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                    default: begin
                        state_q     <= S_IDLE;
                        dec_reset_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rd_req     = can_req;
    assign rd_adr     = rd_adr_q;
    assign fifo_we    = fifo_we_q;
    assign fifo_wd    = fifo_wd_q;
    assign dec_reset  = dec_reset_q;
    assign busy       = (state_q != S_IDLE);
    assign done_irq   = done_irq_q;
    assign err        = err_q;
    assign words_left = words_left_q;

endmodule
